// File: rtl/fifo_burst_drain_arbiter_if.sv
// Output stream bundle of the burst drain arbiter.
// master drives data/ch/last/valid, slave drives ready.
interface fifo_burst_drain_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_W       = 1
);
  logic [DATA_WIDTH-1:0] m_data;
  logic [CH_W-1:0]       m_ch;
  logic                  m_last;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data, m_ch, m_last, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_ch, m_last, m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_burst_drain_arbiter.sv
// Round-robin burst read scheduler draining N_CH FWFT FIFOs
// into one registered valid/ready stream (ch_* FIFO side, m stream, busy).
module fifo_burst_drain_arbiter #(
  parameter int N_CH       = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_LEN  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_CH-1:0]                  ch_empty,
  input  logic [N_CH*(ADDR_WIDTH+1)-1:0]   ch_level,
  input  logic [N_CH*DATA_WIDTH-1:0]       ch_rd_data,
  output logic [N_CH-1:0]                  ch_rd_en,
  input  logic [N_CH-1:0]                  ch_mask,
  input  logic                             flush,
  fifo_burst_drain_arbiter_if.master       m,
  output logic                             busy
);

  localparam int LW   = ADDR_WIDTH + 1;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [LW-1:0] BL  = LW'(BURST_LEN);
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [CH_W-1:0] TOP = CH_W'(N_CH - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nx;
  logic [CH_W-1:0] grant, rr_ptr, pick;
  logic [LW-1:0]   burst_cnt, pick_cnt;
  logic [LW-1:0]   lvl [N_CH];
  logic [N_CH-1:0] elig;
  logic            found, pop, last_pop;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      lvl[i]  = ch_level[i*LW +: LW];
      elig[i] = ch_mask[i] &&
                ((lvl[i] >= BL) ||
                 (flush && (lvl[i] != '0)));
    end
  end

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % N_CH]) begin
        found = 1'b1;
        pick  = CH_W'((int'(rr_ptr) + k) % N_CH);
      end
    end
  end

  assign pick_cnt = (lvl[pick] >= BL) ? BL : lvl[pick];

  assign pop = (state == BURST) &&
               !ch_empty[grant] &&
               (!m.m_valid || m.m_ready);
  assign last_pop = pop && (burst_cnt == ONE);
  assign busy = (state == BURST);

  always_comb begin
    ch_rd_en = '0;
    if (pop) ch_rd_en[grant] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (found) state_nx = BURST;
      BURST: if (last_pop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      if ((state == IDLE) && found) begin
        grant     <= pick;
        burst_cnt <= pick_cnt;
      end
      if (pop) burst_cnt <= burst_cnt - ONE;
      if (last_pop)
        rr_ptr <= (grant == TOP) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.m_data  <= '0;
      m.m_ch    <= '0;
      m.m_last  <= 1'b0;
      m.m_valid <= 1'b0;
    end else if (pop) begin
      m.m_data  <= ch_rd_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      m.m_ch    <= grant;
      m.m_last  <= (burst_cnt == ONE);
      m.m_valid <= 1'b1;
    end else if (m.m_valid && m.m_ready) begin
      m.m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain_arbiter.sv
// Randomized bench for fifo_burst_drain_arbiter with FIFO models,
// a transaction scoreboard and directed burst scenarios.
module tb_fifo_burst_drain_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = AW + 1;
  localparam int BL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  ch_empty, ch_rd_en, ch_mask;
  logic [N*LW-1:0] ch_level;
  logic [N*DW-1:0] ch_rd_data;
  logic          flush, busy;

  fifo_burst_drain_arbiter_if #(.DATA_WIDTH(DW), .CH_W(1)) mif ();

  fifo_burst_drain_arbiter #(
    .N_CH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_empty(ch_empty), .ch_level(ch_level),
    .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en),
    .ch_mask(ch_mask), .flush(flush),
    .m(mif), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            c;
    bit            last;
  } word_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] fq [N][$];
  word_t outq [$];
  int seq = 0;

  bit mb = 0;
  int mg = 0, mrem = 0, mrr = 0;

  int acc [N];
  int burst_ch [$];
  int burst_len [$];
  int cur_len = 0;
  int rmode = 0;
  int stall = 0;
  bit stall_armed = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < N; i++) begin
      ch_empty[i] = (fq[i].size() == 0);
      ch_level[i*LW +: LW] = LW'(fq[i].size());
      ch_rd_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic push(int c, int n);
    for (int k = 0; k < n; k++) begin
      fq[c].push_back({8'(c), 24'(seq)});
      seq++;
    end
    drive_fifo();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) acc[i] = 0;
    burst_ch.delete();
    burst_len.delete();
  endtask

  task automatic step();
    bit v, r, pexp;
    int osz, lv, idx;
    logic [N-1:0] en_seen, en_exp;
    word_t w;
    @(negedge clk);
    en_seen = ch_rd_en;
    v = mif.m_valid;
    r = mif.m_ready;
    if (rst_n) begin
      check("busy", busy, mb);
      check("m_valid", v, outq.size() != 0);
      osz = outq.size();
      if (v && !r && osz > 0) begin
        check("hold_data", mif.m_data, outq[0].d);
        check("hold_ch", mif.m_ch, outq[0].c);
      end
      if (v && r && osz > 0) begin
        w = outq.pop_front();
        check("m_data", mif.m_data, w.d);
        check("m_ch", mif.m_ch, w.c);
        check("m_last", mif.m_last, w.last);
        acc[w.c]++;
        cur_len++;
        if (rmode == 2 && stall_armed && cur_len == 4) begin
          stall = 3;
          stall_armed = 0;
        end
        if (w.last) begin
          burst_ch.push_back(w.c);
          burst_len.push_back(cur_len);
          cur_len = 0;
        end
      end
      pexp = mb && fq[mg].size() != 0 && (osz == 0 || r);
      en_exp = pexp ? (N'(1) << mg) : '0;
      check("rd_en", en_seen, en_exp);
      if (pexp) begin
        w.d = fq[mg][0];
        w.c = mg;
        w.last = (mrem == 1);
        outq.push_back(w);
        mrem--;
        if (mrem == 0) begin
          mb = 0;
          mrr = (mg + 1) % N;
        end
      end else if (!mb) begin
        for (int k = 0; k < N; k++) begin
          idx = (mrr + k) % N;
          lv = fq[idx].size();
          if (!mb && ch_mask[idx] &&
              (lv >= BL || (flush && lv != 0))) begin
            mb = 1;
            mg = idx;
            mrem = (lv < BL) ? lv : BL;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (en_seen[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    case (rmode)
      1: mif.m_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall > 0) begin
          mif.m_ready = 1'b0;
          stall--;
        end else mif.m_ready = 1'b1;
      end
      default: mif.m_ready = 1'b1;
    endcase
    drive_fifo();
  endtask

  task automatic drain(int n);
    rmode = 0;
    flush = 1'b1;
    ch_mask = '1;
    for (int k = 0; k < n; k++) step();
    flush = 1'b0;
    check("drain_left",
          fq[0].size() + fq[1].size() + outq.size() + int'(mb), 0);
    clear_stats();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ch_mask = '1;
    mif.m_ready = 1'b1;
    drive_fifo();
    #1;
    check("rst_valid", mif.m_valid, 0);
    check("rst_data", mif.m_data, 0);
    check("rst_ch", mif.m_ch, 0);
    check("rst_last", mif.m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", ch_rd_en, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();

    // fairness: two full channels alternate from ch0
    push(0, 64);
    push(1, 64);
    for (int k = 0; k < 150; k++) step();
    check("fair_nbursts", burst_ch.size(), 8);
    for (int b = 0; b < 8 && b < burst_ch.size(); b++) begin
      check("fair_ch", burst_ch[b], b % 2);
      check("fair_len", burst_len[b], BL);
    end
    drain(20);

    // single full burst from ch0
    push(0, 16);
    for (int k = 0; k < 30; k++) step();
    check("single_words", acc[0], 16);
    check("single_nbursts", burst_ch.size(), 1);
    if (burst_len.size() > 0) check("single_len", burst_len[0], 16);
    drain(10);

    // backpressure after word 5
    push(0, 16);
    rmode = 2;
    stall_armed = 1;
    for (int k = 0; k < 40; k++) step();
    check("bp_armed_used", stall_armed, 0);
    check("bp_words", acc[0], 16);
    if (burst_len.size() > 0) check("bp_len", burst_len[0], 16);
    drain(10);

    // flush makes a short channel eligible
    push(1, 5);
    for (int k = 0; k < 10; k++) step();
    check("noflush_words", acc[1], 0);
    flush = 1'b1;
    for (int k = 0; k < 20; k++) step();
    flush = 1'b0;
    check("flush_words", acc[1], 5);
    check("flush_nbursts", burst_ch.size(), 1);
    if (burst_len.size() > 0) check("flush_len", burst_len[0], 5);
    drain(10);

    // mask: only ch1, cleared mid-burst
    ch_mask = 2'b10;
    push(0, 32);
    push(1, 32);
    for (int k = 0; k < 5 && !mb; k++) step();
    check("mask_granted", mb, 1);
    for (int k = 0; k < 4; k++) step();
    ch_mask = 2'b00;
    for (int k = 0; k < 60; k++) step();
    check("mask_ch1", acc[1], 16);
    check("mask_ch0", acc[0], 0);
    check("mask_nbursts", burst_ch.size(), 1);
    drain(120);

    // reset in the middle of a burst
    push(0, 40);
    push(1, 40);
    for (int k = 0; k < 10 && !(mif.m_valid && cur_len > 2); k++) step();
    check("rst_mid_valid_pre", mif.m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstm_valid", mif.m_valid, 0);
    check("rstm_last", mif.m_last, 0);
    check("rstm_rd_en", ch_rd_en, 0);
    check("rstm_busy", busy, 0);
    outq.delete();
    mb = 0;
    mrr = 0;
    cur_len = 0;
    step();
    step();
    rst_n = 1'b1;
    clear_stats();
    for (int k = 0; k < 30; k++) step();
    check("rstm_nbursts", burst_ch.size() > 0, 1);
    if (burst_ch.size() > 0) check("rstm_first_ch", burst_ch[0], 0);
    drain(120);

    // random traffic
    rmode = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++)
        if (fq[c].size() < 100 && $urandom_range(0, 2) == 0)
          push(c, $urandom_range(1, 4));
      if ($urandom_range(0, 63) == 0) ch_mask = N'($urandom);
      if ($urandom_range(0, 31) == 0) flush = $urandom_range(0, 1) == 1;
      step();
    end
    drain(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drain_arbiter.md
Name: fifo_burst_drain_arbiter

Overview:
- Round-robin read scheduler that drains N_CH distributed FIFOs (e.g. Left/Right channel FIFOs) into one registered valid/ready stream, in bursts.
- Sits on the FIFO read side and drives each FIFO's rd_en.
- Uses each FIFO's rd_water_level to grant only channels that can supply a full burst, or any non-empty channel when flushing.
- Tags every output word with its source channel and marks the last word of each burst.

Parameters:
- N_CH, 2, number of FIFO channels (2..8).
- DATA_WIDTH, 32, FIFO word width.
- ADDR_WIDTH, 10, FIFO address width; level width is ADDR_WIDTH+1.
- BURST_LEN, 16, maximum words per grant (1..2^ADDR_WIDTH).
- CH_W (derived), max(1, clog2(N_CH)).

Ports:
- clk, in, 1, single clock; all FIFO read ports run on this clock.
- rst_n, in, 1, asynchronous active-low reset.
- ch_empty, in, N_CH, per-channel FIFO empty flag.
- ch_level, in, N_CH*(ADDR_WIDTH+1), per-channel rd_water_level, packed with channel 0 in the LSBs.
- ch_rd_data, in, N_CH*DATA_WIDTH, per-channel FIFO rd_data (head word, first-word-fall-through), packed.
- ch_rd_en, out, N_CH, per-channel pop strobe, one-hot or zero.
- ch_mask, in, N_CH, 1 = channel may be granted.
- flush, in, 1, 1 = channels with 0 < level < BURST_LEN are also eligible.
- m_data, out, DATA_WIDTH, output word.
- m_ch, out, CH_W, source channel of m_data.
- m_last, out, 1, last word of the current burst.
- m_valid, out, 1, output word valid.
- m_ready, in, 1, downstream accept.
- busy, out, 1, 1 while in BURST state.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0, burst_cnt=0. Outputs: m_valid=0, m_data=0, m_ch=0, m_last=0, busy=0, ch_rd_en=0. Reset acts immediately mid-burst; data popped but not yet accepted is discarded.
- Channel i is eligible when ch_mask[i]=1 and either ch_level[i] >= BURST_LEN, or (flush=1 and ch_level[i] != 0).
- IDLE state:
  - If any channel is eligible, grant the first eligible channel searching upward from rr_ptr, modulo N_CH.
  - Latch grant and set burst_cnt = min(ch_level[grant], BURST_LEN).
  - Move to BURST on the next cycle.
  - No pop occurs in IDLE, so the gap between bursts is exactly one cycle.
- BURST state:
  - busy=1.
  - pop = !ch_empty[grant] && (!m_valid || m_ready).
  - ch_rd_en[grant] = pop, combinational; all other bits are 0.
  - On pop: m_data <= ch_rd_data[grant], m_ch <= grant, m_valid <= 1, m_last <= (burst_cnt==1), burst_cnt decrements.
  - On the pop with burst_cnt==1: rr_ptr <= (grant+1) mod N_CH, state <= IDLE.
- Output register: if m_valid && m_ready && !pop, then m_valid <= 0. m_data, m_ch and m_last hold while m_valid && !m_ready. No word is dropped or duplicated.
- Steady-state throughput: 1 word/cycle within a burst when m_ready=1.
- Level reading: only this block pops the FIFOs, so the level cannot fall below the latched burst_cnt during a burst. A lagging (conservative) water level only delays grants.
- Defensive stall: if ch_empty[grant]=1 in BURST, no pop occurs and the block waits.
- Changes to ch_mask or flush during a burst take effect at the next IDLE arbitration; the current burst always completes its latched count.
- The burst_cnt counter is ADDR_WIDTH+1 bits wide. rr_ptr wraps from N_CH-1 to 0.
- m_last=1 on the single word of a 1-word burst.

Test Plan:
- Reset check: assert rst_n=0 mid-burst with m_valid=1 -> m_valid, m_last, ch_rd_en and busy go to 0 immediately. After release, the first grant is ch0 when both channels are eligible.
- Single burst: ch0 level 16, ch1 level 0, m_ready=1 -> 1 idle cycle, then ch_rd_en[0] high for 16 consecutive cycles. m_valid is high for 16 cycles with m_ch=0, and m_last=1 only on the 16th word.
- Fairness: both levels 64, m_ready=1 -> m_ch burst sequence is 0,1,0,1, with 16 words each and one bubble cycle between bursts.
- Backpressure: drop m_ready for 3 cycles after word 5 of a burst -> m_data and m_ch hold word 5 and ch_rd_en=0 during the stall. All 16 words arrive in order with no loss.
- Flush: ch1 level 5, flush=0 -> no grant. Raise flush=1 -> burst of exactly 5 words, m_ch=1, m_last on word 5, then return to IDLE.
- Mask: both channels eligible, ch_mask=2'b10 -> only ch1 is granted. Clear ch_mask[1] mid-burst -> that burst completes all 16 words, then no further grants occur.
